i2c_cond_detector: RTL
======================

// Module: i2c_cond_detector
// PURPOSE
//  Parametrised front end for the I2C peripheral; runs on the fast system clock clk.
//  Synchronises and glitch-filters SCL/SDA, then detects START, REPEATED START and STOP.
//  Issues a per-bit strobe with a 0..8 bit index, and tracks bus-busy state.
//  Feeds the I2C peripheral controller with single-cycle event pulses and sticky flags.
// PARAMETERS
//  SYNC_STAGES     2      flops in each input synchroniser chain (min 2)
//  FILTER_LEN      3      consecutive equal samples needed to accept a new line level (1..15)
//  TIMEOUT_CYCLES  50000  clk cycles of SCL held low while busy that declare a bus timeout
// PORTS
//  clk            in   1  system clock
//  reset          in   1  synchronous, active-high reset
//  scl_in         in   1  raw SCL from pad, asynchronous
//  sda_in         in   1  raw SDA from pad, asynchronous
//  clear_flags    in   1  clears all sticky flags
//  start_pulse    out  1  one-cycle strobe: START detected from IDLE
//  rstart_pulse   out  1  one-cycle strobe: START detected while ACTIVE
//  stop_pulse     out  1  one-cycle strobe: STOP detected
//  bit_valid      out  1  one-cycle strobe on filtered SCL rising edge while ACTIVE
//  bit_value      out  1  filtered SDA captured with bit_valid; holds until next bit_valid
//  bit_index      out  4  index of the captured bit, 0..8 (8 = ACK slot)
//  bus_busy       out  1  1 while state is ACTIVE
//  seen_start     out  1  sticky; set by start_pulse
//  seen_rstart    out  1  sticky; set by rstart_pulse
//  seen_stop      out  1  sticky; set by stop_pulse
//  timeout_pulse  out  1  one-cycle strobe on bus timeout; constant 0 without I2C_TIMEOUT_EN
// BEHAVIOUR
//  Reset values:
//   - synchroniser flops and filtered SCL/SDA = 1 (idle bus); filter counters = 0
//   - all pulses, bit_value, bus_busy and sticky flags = 0; bit_index = 0; state = IDLE
//  Filter:
//   - the filtered level flips only after FILTER_LEN consecutive synced samples differ from it
//   - any matching sample clears the counter, so shorter glitches are rejected entirely
//  Edges: scl_f/sda_f are compared against their previous-cycle values (prev registers reset to 1).
//  Latency: raw pin change -> pulse output is SYNC_STAGES + FILTER_LEN + 1 clk cycles.
//  State machine (IDLE, ACTIVE); conditions are evaluated only when SCL is stable high:
//   - sda_f falls, scl_f and its prev both 1, state IDLE   -> start_pulse, go ACTIVE, bit_index := 0
//   - sda_f falls, scl_f and its prev both 1, state ACTIVE -> rstart_pulse, bit_index := 0
//   - sda_f rises, scl_f and its prev both 1               -> stop_pulse, go IDLE; also valid from IDLE
//  Bit strobe:
//   - scl_f rises while ACTIVE -> bit_valid = 1, bit_value = sda_f
//   - bit_index is then the index of the current bit; the counter advances 0..8 and wraps 8 -> 0
//   - first bit after START/RSTART has bit_index 0
//  Simultaneous SCL and SDA edges in the same cycle are data-phase:
//   - no START/RSTART/STOP is reported
//   - bit_valid still fires if SCL rose
//  SCL rising edges in IDLE produce no bit_valid.
//  Sticky flags:
//   - set on their pulse and cleared by clear_flags
//   - when a set and clear_flags occur in the same cycle, the set wins
//  Reset asserted mid-transfer: return to reset values on the next clk edge; no pulse is emitted.
// CONFIGURATION
//  I2C_TIMEOUT_EN defined:
//   - a 32-bit counter runs while ACTIVE and scl_f == 0; it clears whenever scl_f == 1 or state is IDLE
//   - when the count reaches TIMEOUT_CYCLES: timeout_pulse for 1 cycle, state -> IDLE, bit_index := 0
//   - sticky flags are unaffected by a timeout
//  I2C_TIMEOUT_EN undefined: no counter logic; timeout_pulse tied 0; port list unchanged.
// STRUCTURE
//  Package i2c_pkg:
//   - typedef enum logic {I2C_IDLE, I2C_ACTIVE} i2c_bus_state_e
//   - localparam I2C_BIT_INDEX_MAX = 4'd8
//   - default values for SYNC_STAGES and FILTER_LEN
//  Sub-module i2c_glitch_filter (params SYNC_STAGES, FILTER_LEN; ports clk, reset, raw_in, filt_out):
//   - synchroniser plus filter; instantiated once for SCL and once for SDA
//  Top level holds the edge detection, FSM, bit counter, sticky flags and timeout logic.
// TESTING
//  1. Reset with both lines high:
//     -> all outputs 0; bus_busy = 0; no pulse within 20 cycles.
//  2. SDA 1->0 with SCL high (defaults):
//     -> start_pulse exactly 6 cycles after the pin change; bus_busy = 1; seen_start = 1.
//  3. After START, clock byte 0xA5 plus ACK = 0:
//     -> 9 bit_valid strobes; bit_value sequence 1,0,1,0,0,1,0,1,0; bit_index 0..8, then wraps to 0.
//  4. Second START without STOP:
//     -> rstart_pulse only, no start_pulse; the next bit_valid carries bit_index 0.
//  5. SDA 0->1 with SCL high:
//     -> stop_pulse, bus_busy = 0; a 2-cycle SDA glitch (< FILTER_LEN) gives no pulse.
//  6. seen_stop set, then clear_flags pulsed in the same cycle as a new start_pulse:
//     -> seen_start = 1, seen_stop = 0.
//  7. I2C_TIMEOUT_EN with TIMEOUT_CYCLES = 100, SCL held low after START:
//     -> timeout_pulse at count 100, bus_busy = 0; without the macro, timeout_pulse stays 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared bus-state type, bit-index limit and default filter parameters for the I2C front end.
package i2c_pkg;
  typedef enum logic {I2C_IDLE, I2C_ACTIVE} i2c_bus_state_e;
  localparam logic [3:0] I2C_BIT_INDEX_MAX = 4'd8;
  localparam int I2C_SYNC_STAGES_DEF = 2;
  localparam int I2C_FILTER_LEN_DEF = 3;
endpackage

// File: rtl/i2c_glitch_filter.sv
// i2c_glitch_filter: synchronises a raw pad input and only accepts a new level after FILTER_LEN equal samples.
module i2c_glitch_filter
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = I2C_SYNC_STAGES_DEF,
  parameter int FILTER_LEN  = I2C_FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic filt_out
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [3:0] r_cnt;
  logic r_filt;
  logic w_smp, w_diff, w_flip;
  assign w_smp  = r_sync[SYNC_STAGES-1];
  assign w_diff = w_smp != r_filt;
  assign w_flip = w_diff && r_cnt == 4'(FILTER_LEN - 1);
  assign filt_out = r_filt;
  // a matching sample clears the run, so glitches shorter than FILTER_LEN vanish
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '1;
      r_cnt  <= '0;
      r_filt <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in};
      r_cnt  <= (w_diff && !w_flip) ? r_cnt + 4'd1 : 4'd0;
      if (w_flip) r_filt <= w_smp;
    end
  end
endmodule

// File: rtl/i2c_cond_detector.sv
// i2c_cond_detector: filtered I2C START/RSTART/STOP detection, bit strobes, bus-busy and sticky flags.
// Optional SCL-low bus timeout is built when I2C_TIMEOUT_EN is defined.
module i2c_cond_detector
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES    = I2C_SYNC_STAGES_DEF,
  parameter int FILTER_LEN     = I2C_FILTER_LEN_DEF,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  input  logic       clear_flags,
  output logic       start_pulse,
  output logic       rstart_pulse,
  output logic       stop_pulse,
  output logic       bit_valid,
  output logic       bit_value,
  output logic [3:0] bit_index,
  output logic       bus_busy,
  output logic       seen_start,
  output logic       seen_rstart,
  output logic       seen_stop,
  output logic       timeout_pulse
);
  if (SYNC_STAGES < 2 || FILTER_LEN < 1 || FILTER_LEN > 15 || TIMEOUT_CYCLES < 1) begin : g_param_err
    $error("i2c_cond_detector: parameter out of range");
  end
  logic w_scl_f, w_sda_f, r_scl_p, r_sda_p, w_scl_hi;
  logic w_start, w_rstart, w_stop, w_bit, w_to;
  i2c_bus_state_e r_state, w_state_nxt;
  logic [3:0] r_bit_cnt, w_bit_cnt_nxt;
  i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .reset(reset), .raw_in(scl_in), .filt_out(w_scl_f)
  );
  i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .reset(reset), .raw_in(sda_in), .filt_out(w_sda_f)
  );
  // conditions need SCL high now and last cycle, so an SCL edge makes it a data-phase change
  assign w_scl_hi = w_scl_f && r_scl_p;
  assign bus_busy = r_state == I2C_ACTIVE;
`ifdef I2C_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  always_ff @(posedge clk) begin
    if (reset || r_state == I2C_IDLE || w_scl_f) r_to_cnt <= '0;
    else r_to_cnt <= r_to_cnt + 32'd1;
  end
  assign w_to = r_state == I2C_ACTIVE && !w_scl_f && r_to_cnt == 32'(TIMEOUT_CYCLES - 1);
`else
  assign w_to = 1'b0;
`endif
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_start       = 1'b0;
    w_rstart      = 1'b0;
    w_stop        = 1'b0;
    w_bit         = 1'b0;
    if (w_scl_hi && !w_sda_f && r_sda_p) begin
      w_start       = r_state == I2C_IDLE;
      w_rstart      = r_state == I2C_ACTIVE;
      w_state_nxt   = I2C_ACTIVE;
      w_bit_cnt_nxt = 4'd0;
    end else if (w_scl_hi && w_sda_f && !r_sda_p) begin
      w_stop      = 1'b1;
      w_state_nxt = I2C_IDLE;
    end else if (w_scl_f && !r_scl_p && r_state == I2C_ACTIVE) begin
      w_bit         = 1'b1;
      w_bit_cnt_nxt = (r_bit_cnt == I2C_BIT_INDEX_MAX) ? 4'd0 : r_bit_cnt + 4'd1;
    end else if (w_to) begin
      w_state_nxt   = I2C_IDLE;
      w_bit_cnt_nxt = 4'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_p       <= 1'b1;
      r_sda_p       <= 1'b1;
      r_state       <= I2C_IDLE;
      r_bit_cnt     <= 4'd0;
      start_pulse   <= 1'b0;
      rstart_pulse  <= 1'b0;
      stop_pulse    <= 1'b0;
      bit_valid     <= 1'b0;
      bit_value     <= 1'b0;
      bit_index     <= 4'd0;
      timeout_pulse <= 1'b0;
      seen_start    <= 1'b0;
      seen_rstart   <= 1'b0;
      seen_stop     <= 1'b0;
    end else begin
      r_scl_p       <= w_scl_f;
      r_sda_p       <= w_sda_f;
      r_state       <= w_state_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      start_pulse   <= w_start;
      rstart_pulse  <= w_rstart;
      stop_pulse    <= w_stop;
      bit_valid     <= w_bit;
      timeout_pulse <= w_to;
      if (w_bit) begin
        bit_value <= w_sda_f;
        bit_index <= r_bit_cnt;
      end else if (w_start || w_rstart || w_to) begin
        bit_index <= 4'd0;
      end
      seen_start  <= start_pulse  || (seen_start  && !clear_flags);
      seen_rstart <= rstart_pulse || (seen_rstart && !clear_flags);
      seen_stop   <= stop_pulse   || (seen_stop   && !clear_flags);
    end
  end
endmodule
